// File: rtl/goto_rep_monitor.sv
// Goto-repetition checker: after each accepted rising edge of a_i, require
// N_HITS (not necessarily consecutive) b_i beats within a TIMEOUT-edge window.
module goto_rep_monitor #(
    parameter int N_HITS  = 2,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             a_i,
    input  logic             b_i,
    output logic             busy_o,
    output logic             pass_o,
    output logic             fail_o,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [15:0]      pass_total_o,
    output logic [15:0]      fail_total_o,
    output logic [15:0]      drop_total_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_HITS);
    localparam logic [CNT_W-1:0] T_LIM = CNT_W'(TIMEOUT);
    localparam bit               HAS_TO = (TIMEOUT != 0);

    // Totals stick at all-ones rather than wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_e           state_q, state_d;
    logic             a_q;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic             busy_q, pass_q, fail_q;
    logic [15:0]      pass_tot_q, fail_tot_q, drop_tot_q;

    logic             rose_s;
    logic [CNT_W-1:0] beat_s;
    logic [CNT_W-1:0] hit_inc_s;
    logic             pass_d, fail_d, drop_d;

    // Next-state, beat counting and window evaluation.
    always_comb begin
        rose_s    = a_i & ~a_q;
        beat_s    = b_i ? ONE : ZERO;
        hit_inc_s = hit_q + beat_s;
        state_d   = state_q;
        hit_d     = hit_q;
        win_d     = win_q;
        pass_d    = 1'b0;
        fail_d    = 1'b0;
        drop_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rose_s && en_i) begin
                    // Overlapping implication: the trigger edge's beat counts.
                    hit_d = beat_s;
                    win_d = ONE;
                    if (beat_s == N_LIM) begin
                        pass_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (HAS_TO && (T_LIM == ONE)) begin
                        fail_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                drop_d = rose_s;
                if (!en_i) begin
                    state_d = ST_IDLE;
                end else if (b_i && (hit_inc_s == N_LIM)) begin
                    hit_d   = hit_inc_s;
                    pass_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (HAS_TO && ((win_q + ONE) == T_LIM)) begin
                    hit_d   = hit_inc_s;
                    fail_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    hit_d   = hit_inc_s;
                    state_d = ST_WAIT;
                    if (HAS_TO) begin
                        win_d = win_q + ONE;
                    end else begin
                        win_d = win_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, registered pulses and saturating totals.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            a_q        <= 1'b0;
            hit_q      <= ZERO;
            win_q      <= ZERO;
            busy_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            pass_tot_q <= 16'h0000;
            fail_tot_q <= 16'h0000;
            drop_tot_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            a_q     <= a_i;
            hit_q   <= hit_d;
            win_q   <= win_d;
            busy_q  <= (state_d == ST_WAIT);
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            if (pass_d) begin
                pass_tot_q <= sat_inc(pass_tot_q);
            end else begin
                pass_tot_q <= pass_tot_q;
            end
            if (fail_d) begin
                fail_tot_q <= sat_inc(fail_tot_q);
            end else begin
                fail_tot_q <= fail_tot_q;
            end
            if (drop_d) begin
                drop_tot_q <= sat_inc(drop_tot_q);
            end else begin
                drop_tot_q <= drop_tot_q;
            end
        end
    end

    assign busy_o       = busy_q;
    assign pass_o       = pass_q;
    assign fail_o       = fail_q;
    assign hit_cnt_o    = hit_q;
    assign pass_total_o = pass_tot_q;
    assign fail_total_o = fail_tot_q;
    assign drop_total_o = drop_tot_q;

endmodule

// File: tb/tb_goto_rep_monitor.sv
// Directed bench for goto_rep_monitor: a scoreboard checks every pass/fail
// pulse of the default instance; two extra instances cover N_HITS=1 and TIMEOUT=0.
module tb_goto_rep_monitor;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic en    = 1'b1;
    logic a     = 1'b0;
    logic b     = 1'b0;

    always #5 clk = ~clk;

    logic        busy, pass, fail;
    logic [7:0]  hit;
    logic [15:0] pt, ft, dt;
    logic        n1_busy, n1_pass, n1_fail;
    logic [7:0]  n1_hit;
    logic [15:0] n1_pt, n1_ft, n1_dt;
    logic        t0_busy, t0_pass, t0_fail;
    logic [7:0]  t0_hit;
    logic [15:0] t0_pt, t0_ft, t0_dt;

    goto_rep_monitor u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .a_i(a), .b_i(b),
        .busy_o(busy), .pass_o(pass), .fail_o(fail), .hit_cnt_o(hit),
        .pass_total_o(pt), .fail_total_o(ft), .drop_total_o(dt)
    );

    goto_rep_monitor #(.N_HITS(1)) u_n1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .a_i(a), .b_i(b),
        .busy_o(n1_busy), .pass_o(n1_pass), .fail_o(n1_fail), .hit_cnt_o(n1_hit),
        .pass_total_o(n1_pt), .fail_total_o(n1_ft), .drop_total_o(n1_dt)
    );

    goto_rep_monitor #(.TIMEOUT(0)) u_t0 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .a_i(a), .b_i(b),
        .busy_o(t0_busy), .pass_o(t0_pass), .fail_o(t0_fail), .hit_cnt_o(t0_hit),
        .pass_total_o(t0_pt), .fail_total_o(t0_ft), .drop_total_o(t0_dt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        is_pass;
        logic [7:0]  hit;
        logic [15:0] pt;
        logic [15:0] ft;
        logic [15:0] dt;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expect_pulse(input logic p, input int h, input int ep, input int ef, input int ed);
        exp_t e;
        e.is_pass = p;
        e.hit     = 8'(h);
        e.pt      = 16'(ep);
        e.ft      = 16'(ef);
        e.dt      = 16'(ed);
        sb.push_back(e);
    endtask

    // Scoreboard monitor: every pulse of the default instance pops one entry.
    always @(negedge clk) begin : mon_p
        exp_t e;
        if (rst_n && (pass || fail)) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got pass=%0b fail=%0b expected no pulse", pass, fail);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", 32'(pass), 32'(e.is_pass));
                chk("pulse_excl", 32'(pass & fail), 32'd0);
                chk("pulse_hit", 32'(hit), 32'(e.hit));
                chk("pulse_pass_total", 32'(pt), 32'(e.pt));
                chk("pulse_fail_total", 32'(ft), 32'(e.ft));
                chk("pulse_drop_total", 32'(dt), 32'(e.dt));
                chk("pulse_busy_low", 32'(busy), 32'd0);
            end
        end
    end

    task automatic step(input logic na, input logic nb);
        a = na;
        b = nb;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        a     = 1'b0;
        b     = 1'b0;
        en    = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : watchdog_p
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim_p
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_pass_total", 32'(pt), 32'd0);
        chk("rst_fail_total", 32'(ft), 32'd0);
        chk("rst_drop_total", 32'(dt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic pass with a gap between beats.
        step(1'b0, 1'b0);
        expect_pulse(1'b1, 2, 1, 0, 0);
        step(1'b1, 1'b0);
        chk("t1_busy_rise", 32'(busy), 32'd1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("t1_busy_fall", 32'(busy), 32'd0);
        idle_n(2);

        // Timeout after 16 window edges with a single beat.
        expect_pulse(1'b0, 1, 1, 1, 0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle_n(13);
        chk("t2_busy_edge15", 32'(busy), 32'd1);
        chk("t2_no_fail_edge15", 32'(fail), 32'd0);
        step(1'b0, 1'b0);
        chk("t2_busy_after_fail", 32'(busy), 32'd0);
        idle_n(2);

        // Second rise during WAIT is dropped.
        expect_pulse(1'b1, 2, 2, 1, 1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("t3_drop_total", 32'(dt), 32'd1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        idle_n(2);

        // Continuous b: pass on beat 2, extra beats ignored.
        expect_pulse(1'b1, 2, 3, 1, 1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        chk("t4_hit_hold", 32'(hit), 32'd2);
        chk("t4_pass_total", 32'(pt), 32'd3);
        chk("t4_busy", 32'(busy), 32'd0);

        // Back-to-back: trigger accepted on the edge of the pulse cycle.
        expect_pulse(1'b1, 2, 4, 1, 1);
        expect_pulse(1'b1, 2, 5, 1, 1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        chk("t5_b2b_accept", 32'(busy), 32'd1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        idle_n(2);

        // Rise on the completing edge is dropped.
        expect_pulse(1'b1, 2, 6, 1, 2);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("t6_drop_on_done", 32'(dt), 32'd2);
        chk("t6_busy", 32'(busy), 32'd0);
        idle_n(2);

        // en low aborts silently; rise in IDLE with en low is not a drop.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        en = 1'b0;
        step(1'b0, 1'b0);
        chk("t7_abort_busy", 32'(busy), 32'd0);
        chk("t7_hit_hold", 32'(hit), 32'd1);
        step(1'b1, 1'b0);
        chk("t7_ignored_busy", 32'(busy), 32'd0);
        chk("t7_no_drop", 32'(dt), 32'd2);
        en = 1'b1;
        idle_n(20);

        // Asynchronous reset mid-attempt.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk("t8_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #3;
        chk("t8_busy", 32'(busy), 32'd0);
        chk("t8_hit", 32'(hit), 32'd0);
        chk("t8_pass_total", 32'(pt), 32'd0);
        chk("t8_fail_total", 32'(ft), 32'd0);
        chk("t8_drop_total", 32'(dt), 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1);
        chk("t8_quiet_busy", 32'(busy), 32'd0);
        chk("t8_quiet_fail_total", 32'(ft), 32'd0);

        // N_HITS=1: beat on the trigger edge passes immediately.
        do_reset();
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("n1_pass", 32'(n1_pass), 32'd1);
        chk("n1_busy", 32'(n1_busy), 32'd0);
        chk("n1_hit", 32'(n1_hit), 32'd1);
        chk("n1_pass_total", 32'(n1_pt), 32'd1);
        step(1'b0, 1'b0);
        chk("n1_pass_one_cycle", 32'(n1_pass), 32'd0);
        chk("n1_busy_after", 32'(n1_busy), 32'd0);
        do_reset();

        // TIMEOUT=0 stays busy; default instance still times out.
        expect_pulse(1'b0, 1, 0, 1, 0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        idle_n(40);
        chk("t0_busy", 32'(t0_busy), 32'd1);
        chk("t0_fail_total", 32'(t0_ft), 32'd0);
        chk("t0_hit", 32'(t0_hit), 32'd1);

        idle_n(3);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/goto_rep_monitor.md
# goto_rep_monitor

Synthesizable checker that implements the goto-repetition rule `$rose(a) |-> strong(b[->N])` in RTL, with a bounded window. It sits beside a request/acknowledge pair (`a` = trigger/request, `b` = acknowledge beat), counts non-consecutive `b` beats after each accepted trigger, and reports pass/fail pulses and running totals. It is used on silicon and FPGA builds where simulator assertions are unavailable.

## Interface
- `N_HITS`, default 2: number of `b` beats required. Must be at least 1.
- `TIMEOUT`, default 16: window length in cycles, counted from the trigger cycle. A value of 0 means no timeout (weak semantics: never fails on time).
- `CNT_W`, default 8: width of the hit and window counters. Must hold both `N_HITS` and `TIMEOUT`.
- `clk`  in  1: single clock. All logic uses the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: monitor enable. Low aborts any attempt and blocks new triggers.
- `a`  in  1: trigger signal, sampled at `clk`.
- `b`  in  1: beat signal, sampled at `clk`.
- `busy`  out  1: an attempt is in progress (state WAIT).
- `pass`  out  1: one-cycle pulse when an attempt succeeds.
- `fail`  out  1: one-cycle pulse when an attempt times out.
- `hit_cnt`  out  CNT_W: beats seen in the current attempt. Holds its last value in IDLE.
- `pass_total`  out  16: saturating count of passes.
- `fail_total`  out  16: saturating count of fails.
- `drop_total`  out  16: saturating count of triggers ignored because an attempt was already busy.

## Operation
- Rise detect: `a_q` registers `a`. A trigger is `rose = a & ~a_q`. `a_q` resets to 0, so if `a` is high at the first edge after reset it counts as a rise.
- States: IDLE and WAIT.
- IDLE to WAIT: on `rose & en`.
  - Implication is overlapping: `b` sampled on the trigger edge counts as beat 1.
  - If that beat already reaches `N_HITS` (only possible when `N_HITS`=1), go straight to pass and stay in IDLE.
- In WAIT, at each edge:
  - If `b`=1, increment `hit_cnt`.
  - When the incremented count equals `N_HITS`: assert `pass` next cycle and return to IDLE. That beat is the match point. Later `b` beats are ignored.
  - Otherwise, if `TIMEOUT`≠0 and the edge is the last one in the window (the trigger edge counts as edge 1 of `TIMEOUT`): assert `fail` next cycle and return to IDLE.
  - If the Nth beat lands on the last window edge, the result is pass.
- `b` beats do not have to be consecutive. Gaps of any length are allowed inside the window.
- A `rose` while in WAIT, or on the same edge that completes an attempt, is not accepted and increments `drop_total`. Only one attempt runs at a time.
- `en` low:
  - In WAIT: return to IDLE on the next edge with no pass or fail.
  - In IDLE: a `rose` is ignored and not counted as dropped.
- A new attempt clears `hit_cnt` to 0 and then applies the trigger-edge beat.
- `pass_total`, `fail_total` and `drop_total` saturate at 16'hFFFF.

## Timing
- Reset values: state IDLE, `a_q`=0, and every output 0 (`busy`, `pass`, `fail`, `hit_cnt`, all three totals).
- Asserting `rst_n` low mid-attempt clears everything immediately. No pass or fail is reported for the aborted attempt.
- All outputs are registered.
- `busy` rises one cycle after the trigger edge. It is never set if the trigger edge itself completes the attempt.
- `pass` is asserted the cycle after the edge holding the Nth beat. `fail` is asserted the cycle after the last window edge. Each lasts exactly one cycle. `pass` and `fail` are never high together.
- `busy` falls in the same cycle that `pass` or `fail` rises.
- A total updates in the same cycle as its pulse.
- Back-to-back attempts: a trigger is accepted on the first edge where the state is IDLE, which is the edge of the pulse cycle or any later edge.

## Test plan
- Trigger at edge 2 (`a` 0→1), `b`=1 at edges 3 and 5, `b`=0 elsewhere, defaults → `pass` pulse after edge 5, `hit_cnt`=2, `pass_total`=1.
- Trigger, then `b`=1 at one edge only and `b`=0 afterwards, `TIMEOUT`=16 → `fail` pulse 16 cycles after the trigger, `hit_cnt`=1, `fail_total`=1. With `TIMEOUT`=0, `busy` stays 1 indefinitely.
- `N_HITS`=1, `b`=1 on the trigger edge → `pass` the next cycle, `busy` never set.
- Second rise of `a` during WAIT, followed by two `b` beats → one `pass` only, `drop_total`=1.
- `b` high continuously after the trigger → `pass` after the edge holding beat 2. Extra beats do not change `hit_cnt` or the totals.
- Mid-WAIT, pull `rst_n` low for half a cycle → all outputs 0 immediately, no pulse. Separately, drop `en` mid-WAIT → IDLE with no pulse.
